freqmeter_channel: RTL
======================

Name: freqmeter_channel

Overview:
- One measurement channel of the frequency meter. Instantiated once per Fin bit inside top.
- Synchronises the asynchronous Fin input into the clk_i domain and detects its rising edges.
- Counts clk_i cycles across a programmable number of whole input periods.
- Delivers the count and the period count to the capture/readout logic through a valid/ready handshake.

Parameters:
- CNT_WIDTH, 30: width of the reference-cycle counter and of ref_count_o.
- PERIODS_WIDTH, 24: width of the period target and of periods_o.
- SYNC_STAGES, 2: number of synchroniser flops on fin_i (minimum 2).

Ports:
- clk_i  in  1  system clock; all logic runs on its rising edge.
- rst_i  in  1  reset, asynchronous, active-low (0 = reset).
- fin_i  in  1  measured input, asynchronous to clk_i.
- start_i  in  1  single-cycle request to start a measurement.
- periods_i  in  PERIODS_WIDTH  number of input periods to measure; sampled when start_i is accepted.
- busy_o  out  1  high in ARM and MEASURE.
- valid_o  out  1  result available.
- ready_i  in  1  consumer accepts the result.
- ref_count_o  out  CNT_WIDTH  clk_i cycles spanning the measured periods.
- periods_o  out  PERIODS_WIDTH  periods actually completed.
- timeout_o  out  1  the measurement ended on counter saturation, not on completion.

Behaviour:
- Reset (rst_i=0, asynchronous): FSM goes to IDLE. All outputs and internal counters clear to 0. Synchroniser flops clear to 0.
- Synchroniser and edge detection:
  - fin_i passes through SYNC_STAGES flops, then one history flop.
  - A rising edge is flagged when the synchronised value is 1 and the history flop is 0.
  - Edge latency is SYNC_STAGES+1 cycles. It is constant, so it cancels out of the result.
- FSM states: IDLE, ARM, MEASURE, DONE.
- IDLE:
  - When start_i=1: latch periods_i (a value of 0 is stored as 1), clear ref_cnt and edge_cnt, go to ARM.
  - An edge in the same cycle as start_i is not used.
- ARM:
  - ref_cnt increments every cycle; it is used as a timeout.
  - On an edge: ref_cnt <= 0, edge_cnt <= 0, go to MEASURE.
  - If ref_cnt reaches all-ones before any edge: go to DONE with timeout_o=1, ref_count_o=all-ones, periods_o=0.
- MEASURE:
  - ref_cnt increments every cycle.
  - On an edge, edge_cnt increments.
  - When an edge makes edge_cnt+1 equal the target: ref_count_o <= ref_cnt+1, periods_o <= target, timeout_o <= 0, go to DONE.
  - If ref_cnt+1 would reach all-ones first: ref_count_o <= all-ones, periods_o <= edge_cnt, timeout_o <= 1, go to DONE.
  - If completion and saturation happen in the same cycle, completion wins.
- DONE:
  - valid_o=1. ref_count_o, periods_o and timeout_o are held stable.
  - When valid_o and ready_i are both 1: valid_o drops next cycle and the FSM returns to IDLE.
  - start_i is ignored in DONE, including in the handshake cycle.
- start_i in ARM or MEASURE is ignored; there is no restart.
- Result registers keep their last value in IDLE. They are updated only on entry to DONE.
- Result arithmetic: for a steady input of period P cycles and target N, ref_count_o = N*P exactly.
- Reset asserted mid-measurement aborts the measurement; no partial result is presented.

Test Plan:
1. Reset: hold rst_i=0 while fin_i toggles -> busy_o=0, valid_o=0, all outputs 0. Release reset -> FSM stays in IDLE with no start.
2. Basic measurement: fin_i = bit 3 of a free-running clk_i counter (period 16), periods_i=4, pulse start_i -> valid_o rises with ref_count_o=64, periods_o=4, timeout_o=0. Holding ready_i=0 keeps valid_o and the data stable for 20 cycles.
3. Period target 0 and 1: fin_i = bit 5 (period 64). periods_i=0 -> ref_count_o=64, periods_o=1. periods_i=1 -> the same result.
4. ARM timeout: CNT_WIDTH=8, fin_i held 0, start_i -> valid_o with timeout_o=1, ref_count_o=255, periods_o=0, about 255 cycles after start.
5. MEASURE timeout: CNT_WIDTH=8, fin_i period 100, periods_i=5 -> timeout_o=1, ref_count_o=255, periods_o=2.
6. Handshake and abort:
   - start_i pulsed during MEASURE -> no effect on the result.
   - start_i together with valid&ready -> FSM returns to IDLE and does not start.
   - rst_i pulsed low mid-MEASURE -> all outputs 0; a following start_i gives a correct fresh result (64 for case 2).

Source files
------------

// File: rtl/freqmeter_channel.sv
// One frequency-meter channel: synchronises fin_i, counts clk_i cycles across a
// programmable number of whole input periods, and hands the result over valid/ready.
module freqmeter_channel #(
    parameter int CNT_WIDTH     = 30,
    parameter int PERIODS_WIDTH = 24,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     fin_i,
    input  logic                     start_i,
    input  logic [PERIODS_WIDTH-1:0] periods_i,
    output logic                     busy_o,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [CNT_WIDTH-1:0]     ref_count_o,
    output logic [PERIODS_WIDTH-1:0] periods_o,
    output logic                     timeout_o
);

    localparam logic [CNT_WIDTH-1:0]     CNT_ONE = 1;
    localparam logic [CNT_WIDTH-1:0]     CNT_MAX = '1;
    localparam logic [PERIODS_WIDTH-1:0] PER_ONE = 1;

    typedef enum logic [1:0] {IDLE, ARM, MEASURE, DONE} state_t;

    state_t                     state, state_d;
    logic [SYNC_STAGES-1:0]     fin_sync_p0;
    logic                       fin_hist_p1;
    logic                       fin_edge;
    logic [CNT_WIDTH-1:0]       ref_cnt, ref_cnt_d;
    logic [PERIODS_WIDTH-1:0]   edge_cnt, edge_cnt_d;
    logic [PERIODS_WIDTH-1:0]   target, target_d;
    logic [CNT_WIDTH-1:0]       ref_count_d;
    logic [PERIODS_WIDTH-1:0]   periods_d;
    logic                       timeout_d;

    // True when the next increment of the reference counter lands on all-ones.
    function automatic logic cnt_saturates(input logic [CNT_WIDTH-1:0] c);
        return (c + CNT_ONE) == CNT_MAX;
    endfunction

    // A zero period target would never complete; treat it as one period.
    function automatic logic [PERIODS_WIDTH-1:0] clamp_target(input logic [PERIODS_WIDTH-1:0] p);
        return (p == '0) ? PER_ONE : p;
    endfunction

    // Stage p0: synchroniser chain; stage p1: history flop for edge detection
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            fin_sync_p0 <= '0;
            fin_hist_p1 <= 1'b0;
        end else begin
            fin_sync_p0 <= {fin_sync_p0[SYNC_STAGES-2:0], fin_i};
            fin_hist_p1 <= fin_sync_p0[SYNC_STAGES-1];
        end
    end

    assign fin_edge = fin_sync_p0[SYNC_STAGES-1] & ~fin_hist_p1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state       <= IDLE;
            ref_cnt     <= '0;
            edge_cnt    <= '0;
            target      <= '0;
            ref_count_o <= '0;
            periods_o   <= '0;
            timeout_o   <= 1'b0;
        end else begin
            state       <= state_d;
            ref_cnt     <= ref_cnt_d;
            edge_cnt    <= edge_cnt_d;
            target      <= target_d;
            ref_count_o <= ref_count_d;
            periods_o   <= periods_d;
            timeout_o   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state;
        ref_cnt_d   = ref_cnt;
        edge_cnt_d  = edge_cnt;
        target_d    = target;
        ref_count_d = ref_count_o;
        periods_d   = periods_o;
        timeout_d   = timeout_o;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    target_d   = clamp_target(periods_i);
                    ref_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (fin_edge) begin
                    ref_cnt_d  = '0;
                    edge_cnt_d = '0;
                    state_d    = MEASURE;
                end else if (cnt_saturates(ref_cnt)) begin
                    ref_count_d = CNT_MAX;
                    periods_d   = '0;
                    timeout_d   = 1'b1;
                    state_d     = DONE;
                end else begin
                    ref_cnt_d = ref_cnt + CNT_ONE;
                end
            end
            MEASURE: begin
                ref_cnt_d = ref_cnt + CNT_ONE;
                if (fin_edge) begin
                    edge_cnt_d = edge_cnt + PER_ONE;
                end
                // Completion takes priority over saturation in the same cycle.
                if (fin_edge && (edge_cnt + PER_ONE) == target) begin
                    ref_count_d = ref_cnt + CNT_ONE;
                    periods_d   = target;
                    timeout_d   = 1'b0;
                    state_d     = DONE;
                end else if (cnt_saturates(ref_cnt)) begin
                    ref_count_d = CNT_MAX;
                    periods_d   = edge_cnt;
                    timeout_d   = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign valid_o = (state == DONE);
    assign busy_o  = (state == ARM) || (state == MEASURE);

endmodule
